// File: rtl/adder_arbiter_pkg.sv
// Shared widths, control-state encoding and overflow helper for the
// round-robin adder arbiter.
package adder_arbiter_pkg;

    localparam int ADD_W = 16;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(
        input logic [ADD_W-1:0] a,
        input logic [ADD_W-1:0] b,
        input logic [ADD_W-1:0] sum
    );
        return (a[ADD_W-1] == b[ADD_W-1]) && (sum[ADD_W-1] != a[ADD_W-1]);
    endfunction

endpackage

// File: rtl/adder_arbiter_adder16.sv
// 16-bit two's-complement adder shared by all requesters.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared 16-bit adder; a single result
// register with valid/ready handshake and a response counter.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [16*NREQ-1:0]    req_a,
    input  logic [16*NREQ-1:0]    req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_ovf,
    output logic [15:0]           txn_count
);

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [ADD_W-1:0]  sum_r;
    logic              ovf_r;
    logic [15:0]       txn_count_r;

    logic              slot_free_s;
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   ptr_next_s;
    logic [NREQ-1:0]   req_ready_s;
    logic [ADD_W-1:0]  op_a_s;
    logic [ADD_W-1:0]  op_b_s;
    logic [ADD_W-1:0]  sum_s;
    logic              xfer_in_s;
    logic              xfer_out_s;

    assign slot_free_s = (state_r == ST_EMPTY) || rsp_ready;
    assign xfer_out_s  = (state_r == ST_FULL) && rsp_ready;

    // Round-robin search starting at ptr_r, wrapping modulo NREQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!grant_found_s && req_valid[idx]) begin
                grant_found_s = 1'b1;
                grant_id_s    = ID_W'(idx);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept, suppressed while the result slot is blocked or in reset.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (!rst && slot_free_s && grant_found_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Pointer successor of the current grant, modulo NREQ.
    always_comb begin
        if (int'(grant_id_s) == NREQ - 1) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = grant_id_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    assign xfer_in_s = |(req_valid & req_ready_s);
    assign op_a_s    = req_a[int'(grant_id_s)*ADD_W +: ADD_W];
    assign op_b_s    = req_b[int'(grant_id_s)*ADD_W +: ADD_W];

    adder16 u_adder16 (
        .a   (op_a_s),
        .b   (op_b_s),
        .sum (sum_s)
    );

    // Control FSM, result register, pointer and response counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            ptr_r       <= {ID_W{1'b0}};
            id_r        <= {ID_W{1'b0}};
            sum_r       <= {ADD_W{1'b0}};
            ovf_r       <= 1'b0;
            txn_count_r <= 16'h0000;
        end else begin
            if (xfer_out_s) begin
                txn_count_r <= txn_count_r + 16'h0001;
            end
            if (xfer_in_s) begin
                ptr_r <= ptr_next_s;
                id_r  <= grant_id_s;
                sum_r <= sum_s;
                ovf_r <= add_ovf(op_a_s, op_b_s, sum_s);
            end
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_r <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!xfer_in_s && xfer_out_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = (state_r == ST_FULL);
    assign rsp_id    = id_r;
    assign rsp_sum   = sum_r;
    assign rsp_ovf   = ovf_r;
    assign txn_count = txn_count_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for the adder path plus
// sequences for fairness, backpressure, mid-run reset and counter wrap.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_ovf;
    logic [15:0] txn_count;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  r;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] cnt0;

        vecs[0] = '{2'd0, 16'd17,    16'd54,    16'd71,    1'b0};
        vecs[1] = '{2'd1, 16'h7FFF,  16'h0001,  16'h8000,  1'b1};
        vecs[2] = '{2'd2, 16'h8000,  16'hFFFF,  16'h7FFF,  1'b1};
        vecs[3] = '{2'd3, 16'd27,    16'hFFF2,  16'd13,    1'b0};
        vecs[4] = '{2'd0, 16'hFF9C,  16'hFF38,  16'hFED4,  1'b0};
        vecs[5] = '{2'd2, 16'hFFFF,  16'h0001,  16'h0000,  1'b0};
        vecs[6] = '{2'd1, 16'h4000,  16'h4000,  16'h8000,  1'b1};
        vecs[7] = '{2'd3, 16'hC000,  16'hBFFF,  16'h7FFF,  1'b1};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready_zero", {28'h0, req_ready}, 32'h0);
        chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_id", {30'h0, rsp_id}, 32'h0);
        chk("rst_sum", {16'h0, rsp_sum}, 32'h0);
        chk("rst_ovf", {31'h0, rsp_ovf}, 32'h0);
        chk("rst_txn", {16'h0, txn_count}, 32'h0);
        req_valid = 4'h0;
        rst = 1'b0;
        tick();

        // Adder vector table, one requester at a time
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'h0;
            req_valid[vecs[i].r] = 1'b1;
            req_a = 64'h0;
            req_b = 64'h0;
            req_a[16*vecs[i].r +: 16] = vecs[i].a;
            req_b[16*vecs[i].r +: 16] = vecs[i].b;
            #1;
            chk("vec_ready", {28'h0, req_ready}, 32'(4'b0001 << vecs[i].r));
            tick();
            req_valid = 4'h0;
            chk("vec_valid", {31'h0, rsp_valid}, 32'h1);
            chk("vec_id", {30'h0, rsp_id}, {30'h0, vecs[i].r});
            chk("vec_sum", {16'h0, rsp_sum}, {16'h0, vecs[i].sum});
            chk("vec_ovf", {31'h0, rsp_ovf}, {31'h0, vecs[i].ovf});
        end
        tick();
        chk("drain_valid", {31'h0, rsp_valid}, 32'h0);
        chk("drain_txn", {16'h0, txn_count}, 32'd8);

        // Fairness: all valid from reset, one grant per cycle in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'(i + 1);
            req_b[16*i +: 16] = 16'(100 * (i + 1));
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_ready", {28'h0, req_ready}, 32'(4'b0001 << (k % 4)));
            tick();
            chk("fair_valid", {31'h0, rsp_valid}, 32'h1);
            chk("fair_id", {30'h0, rsp_id}, 32'(k % 4));
            chk("fair_sum", {16'h0, rsp_sum}, 32'(101 * ((k % 4) + 1)));
        end
        chk("fair_txn", {16'h0, txn_count}, 32'd4);

        // Backpressure: 11+37 held while rsp_ready low
        do_reset();
        req_valid = 4'b0001;
        req_a = 64'h0;
        req_b = 64'h0;
        req_a[15:0]  = 16'd11;
        req_b[15:0]  = 16'd37;
        req_a[31:16] = 16'd5;
        req_b[31:16] = 16'd6;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0010;
        chk("bp_load", {16'h0, rsp_sum}, 32'd48);
        cnt0 = txn_count;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", {28'h0, req_ready}, 32'h0);
            tick();
            chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_sum", {16'h0, rsp_sum}, 32'd48);
            chk("bp_id", {30'h0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'h0, req_ready}, 32'b0010);
        tick();
        req_valid = 4'h0;
        chk("bp_next_sum", {16'h0, rsp_sum}, 32'd11);
        chk("bp_next_id", {30'h0, rsp_id}, 32'd1);
        chk("bp_txn", {16'h0, txn_count}, {16'h0, cnt0 + 16'd1});

        // Reset while FULL with requests pending
        do_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        tick();
        chk("mr_full", {31'h0, rsp_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mr_ready_in_rst", {28'h0, req_ready}, 32'h0);
        tick();
        chk("mr_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mr_txn", {16'h0, txn_count}, 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("mr_restart_ready", {28'h0, req_ready}, 32'b0001);
        tick();
        chk("mr_restart_id", {30'h0, rsp_id}, 32'd0);
        req_valid = 4'h0;

        // Counter wrap: 65535 transfer outs, then one more
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_max", {16'h0, txn_count}, 32'h0000FFFF);
        tick();
        chk("wrap_zero", {16'h0, txn_count}, 32'h0);
        req_valid = 4'h0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
